// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm scanner: FSM state encoding,
// default input width and the default truth table.
package minterm_pkg;

    localparam int DEFAULT_N = 3;
    localparam int DEPTH     = 1 << DEFAULT_N;

    // y = ~a&~b&~c | a&~b&~c | a&~b&c  (indices 0, 4 and 5)
    localparam logic [DEPTH-1:0] SILLY_TT = 8'h31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage : minterm_pkg

// File: rtl/minterm_scanner_tt_lookup.sv
// Truth-table lookup: reports whether the function output at idx equals the
// requested target value.
module tt_lookup #(
    parameter int                  N     = minterm_pkg::DEFAULT_N,
    parameter logic [(1<<N)-1:0]   TRUTH = minterm_pkg::SILLY_TT
) (
    input  logic [N-1:0] idx,
    input  logic         want,
    output logic         match
);

    assign match = (TRUTH[idx] == want);

endmodule : tt_lookup

// File: rtl/minterm_scanner.sv
// Sweeps every input vector of a parameterised truth table and streams the
// indices whose output equals the captured target over a valid/ready port.
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int                  N     = DEFAULT_N,
    parameter logic [(1<<N)-1:0]   TRUTH = SILLY_TT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         want,
    output logic         busy,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         done,
    output logic [N:0]   count
);

    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    state_e       state_q, state_d;
    logic [N-1:0] idx_q, idx_d;
    logic         want_q, want_d;
    logic         m_valid_q, m_valid_d;
    logic [N-1:0] m_data_q, m_data_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [N:0]   count_q, count_d;

    logic match;
    logic hs;
    logic stall;

    tt_lookup #(
        .N     (N),
        .TRUTH (TRUTH)
    ) u_tt_lookup (
        .idx   (idx_q),
        .want  (want_q),
        .match (match)
    );

    assign hs    = m_valid_q &  m_ready;
    assign stall = m_valid_q & ~m_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        want_d    = want_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        count_d   = count_q;

        if (hs) begin
            count_d = count_q + (N+1)'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    count_d   = '0;
                    want_d    = want;
                    busy_d    = 1'b1;
                    m_valid_d = 1'b0;
                end
            end

            SCAN: begin
                // A stall freezes the presented vector and the sweep position.
                if (!stall) begin
                    m_valid_d = match;
                    m_data_d  = idx_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + N'(1);
                    end
                end
            end

            DRAIN: begin
                // Finish only once the final candidate, if any, has been taken.
                if (!stall) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            want_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            want_q    <= want_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule : minterm_scanner

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: default table and an all-zero table,
// minterm/maxterm sweeps, back-pressure, async reset and start overlap.
module tb_minterm_scanner;
    import minterm_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         want = 1'b0;
    logic         m_ready = 1'b1;

    logic         busy0, m_valid0, done0;
    logic [N-1:0] m_data0;
    logic [N:0]   count0;
    logic         busy1, m_valid1, done1;
    logic [N-1:0] m_data1;
    logic [N:0]   count1;

    int sel = 0;
    logic         o_busy, o_valid, o_done;
    logic [N-1:0] o_data;
    logic [N:0]   o_count;

    int total = 0;
    int bad   = 0;

    int exp_d[8];
    int exp_e[8];
    int exp_n;
    int exp_done;
    int exp_count;

    always #5 clk = ~clk;

    minterm_scanner #(.N(N), .TRUTH(8'h31)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .want(want),
        .busy(busy0), .m_valid(m_valid0), .m_ready(m_ready),
        .m_data(m_data0), .done(done0), .count(count0)
    );

    minterm_scanner #(.N(N), .TRUTH(8'h00)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .want(want),
        .busy(busy1), .m_valid(m_valid1), .m_ready(m_ready),
        .m_data(m_data1), .done(done1), .count(count1)
    );

    always_comb begin
        if (sel == 1) begin
            o_busy = busy1; o_valid = m_valid1; o_done = done1;
            o_data = m_data1; o_count = count1;
        end else begin
            o_busy = busy0; o_valid = m_valid0; o_done = done0;
            o_data = m_data0; o_count = count0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses (or holds) start, then samples 1 time unit after each edge k,
    // logging every handshake as (data, k) and the edge at which done shows.
    task automatic run_sweep(input string name, input logic w, input int stall_data,
                             input int stall_cycles, input bit hold);
        int got_d[$];
        int got_e[$];
        int done_e     = -1;
        int stall_left = 0;
        bit stalling   = 1'b0;
        bit stalled    = 1'b0;
        want    = w;
        start   = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            want  = ~w;
        end
        check({name, "_acc_busy"}, 32'(o_busy), 32'd1);
        check({name, "_acc_count"}, 32'(o_count), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (o_done) begin
                done_e = k;
                break;
            end
            if (stalling) begin
                check($sformatf("%s_stall_valid_k%0d", name, k), 32'(o_valid), 32'd1);
                check($sformatf("%s_stall_data_k%0d", name, k), 32'(o_data), 32'(stall_data));
                stall_left--;
                if (stall_left == 0) begin
                    stalling = 1'b0;
                    m_ready  = 1'b1;
                end
            end else if (!stalled && stall_cycles > 0 && o_valid && int'(o_data) == stall_data) begin
                stalled    = 1'b1;
                stalling   = 1'b1;
                stall_left = stall_cycles;
                m_ready    = 1'b0;
            end
            if (o_valid && m_ready) begin
                got_d.push_back(int'(o_data));
                got_e.push_back(k);
            end
        end
        m_ready = 1'b1;
        if (done_e < 0) begin
            check({name, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_done_edge"}, 32'(done_e), 32'(exp_done));
            check({name, "_count"}, 32'(o_count), 32'(exp_count));
            check({name, "_busy_at_done"}, 32'(o_busy), 32'd0);
        end
        check({name, "_n_items"}, 32'(got_d.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), 32'(got_d[i]), 32'(exp_d[i]));
            check($sformatf("%s_edge%0d", name, i), 32'(got_e[i]), 32'(exp_e[i]));
        end
        if (!hold) begin
            @(posedge clk); #1;
            check({name, "_done_pulse"}, 32'(o_done), 32'd0);
            check({name, "_count_hold"}, 32'(o_count), 32'(exp_count));
        end
    endtask

    task automatic expect_default_ones();
        exp_d = '{0, 4, 5, 0, 0, 0, 0, 0};
        exp_e = '{1, 5, 6, 0, 0, 0, 0, 0};
        exp_n = 3; exp_done = 9; exp_count = 3;
    endtask

    initial begin
        bit found;

        #2;
        check("rst_valid", 32'(m_valid0), 32'd0);
        check("rst_data", 32'(m_data0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_count", 32'(count0), 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // Minterms of the default table.
        expect_default_ones();
        run_sweep("t1", 1'b1, -1, 0, 1'b0);

        // Maxterms; index 7 is still on the bus when DRAIN is entered.
        exp_d = '{1, 2, 3, 6, 7, 0, 0, 0};
        exp_e = '{2, 3, 4, 7, 8, 0, 0, 0};
        exp_n = 5; exp_done = 9; exp_count = 5;
        run_sweep("t2", 1'b0, -1, 0, 1'b0);

        // Four stalled edges while 4 is presented.
        exp_d = '{0, 4, 5, 0, 0, 0, 0, 0};
        exp_e = '{1, 9, 10, 0, 0, 0, 0, 0};
        exp_n = 3; exp_done = 13; exp_count = 3;
        run_sweep("t3", 1'b1, 4, 4, 1'b0);

        // All-zero table: nothing matches want=1.
        sel = 1;
        exp_n = 0; exp_done = 9; exp_count = 0;
        run_sweep("t4", 1'b1, -1, 0, 1'b0);
        sel = 0;

        // Asynchronous reset right after 4 appears.
        want  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_valid0 && m_data0 == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t5_saw_4", 32'(found), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(m_valid0), 32'd0);
        check("t5_rst_data", 32'(m_data0), 32'd0);
        check("t5_rst_busy", 32'(busy0), 32'd0);
        check("t5_rst_done", 32'(done0), 32'd0);
        check("t5_rst_count", 32'(count0), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        expect_default_ones();
        run_sweep("t5", 1'b1, -1, 0, 1'b0);

        // start held high for the whole sweep and past done.
        expect_default_ones();
        run_sweep("t6", 1'b1, -1, 0, 1'b1);
        check("t6_done_seen", 32'(done0), 32'd1);
        @(posedge clk); #1;
        check("t6_reaccept_busy", 32'(busy0), 32'd1);
        check("t6_reaccept_count", 32'(count0), 32'd0);
        check("t6_reaccept_done", 32'(done0), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        check("t6_first_valid", 32'(m_valid0), 32'd1);
        check("t6_first_data", 32'(m_data0), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done0) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_second_done", 32'(found), 32'd1);
        check("t6_second_count", 32'(count0), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_minterm_scanner
